// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one word-addressed data memory between two requesters,
// with read-modify-write sequencing for byte-masked stores and range checking.
module dmem_arbiter #(
  parameter int MEM_SIZE = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_0,
  output logic        req_ready_0,
  input  logic        req_we_0,
  input  logic [31:0] req_addr_0,
  input  logic [31:0] req_wdata_0,
  input  logic [3:0]  req_be_0,
  output logic        rsp_valid_0,
  output logic [31:0] rsp_rdata_0,
  output logic        rsp_err_0,
  input  logic        req_valid_1,
  output logic        req_ready_1,
  input  logic        req_we_1,
  input  logic [31:0] req_addr_1,
  input  logic [31:0] req_wdata_1,
  input  logic [3:0]  req_be_1,
  output logic        rsp_valid_1,
  output logic [31:0] rsp_rdata_1,
  output logic        rsp_err_1,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RMW = 1'b1} state_t;

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);

  state_t      state_r;
  logic        prio_r;
  logic        rmw_port_r;
  logic [31:0] rmw_addr_r;
  logic [31:0] rmw_data_r;

  logic        grant_valid_s;
  logic        grant_port_s;
  logic        accept_s;
  logic        sel_we_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic [3:0]  sel_be_s;
  logic        in_range_s;
  logic        partial_s;
  logic        full_store_s;
  logic [31:0] merged_s;

  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

  // Round-robin grant: the prio port wins when valid, otherwise the other port
  always_comb begin
    logic pri_valid;
    logic oth_valid;
    pri_valid = prio_r ? req_valid_1 : req_valid_0;
    oth_valid = prio_r ? req_valid_0 : req_valid_1;
    if (pri_valid) begin
      grant_valid_s = 1'b1;
      grant_port_s  = prio_r;
    end else if (oth_valid) begin
      grant_valid_s = 1'b1;
      grant_port_s  = ~prio_r;
    end else begin
      grant_valid_s = 1'b0;
      grant_port_s  = prio_r;
    end
  end

  assign sel_we_s     = grant_port_s ? req_we_1    : req_we_0;
  assign sel_addr_s   = grant_port_s ? req_addr_1  : req_addr_0;
  assign sel_wdata_s  = grant_port_s ? req_wdata_1 : req_wdata_0;
  assign sel_be_s     = grant_port_s ? req_be_1    : req_be_0;
  assign in_range_s   = (sel_addr_s < MEM_LIMIT);
  assign partial_s    = sel_we_s && (sel_be_s != 4'h0) && (sel_be_s != 4'hF);
  assign full_store_s = sel_we_s && (sel_be_s == 4'hF);
  assign merged_s     = (mem_rdata & ~be_to_mask(sel_be_s)) | (sel_wdata_s & be_to_mask(sel_be_s));

  assign accept_s    = rst_n && (state_r == ST_IDLE) && grant_valid_s;
  assign req_ready_0 = accept_s && !grant_port_s;
  assign req_ready_1 = accept_s && grant_port_s;

  // Memory port drive: RMW write-back, accepted in-range access, or quiet zeros
  always_comb begin
    mem_a     = 32'h0;
    mem_wdata = 32'h0;
    mem_we    = 1'b0;
    if (!rst_n) begin
      mem_we = 1'b0;
    end else if (state_r == ST_RMW) begin
      mem_a     = rmw_addr_r;
      mem_wdata = rmw_data_r;
      mem_we    = 1'b1;
    end else if (accept_s && in_range_s) begin
      mem_a = sel_addr_s;
      if (full_store_s) begin
        mem_wdata = sel_wdata_s;
        mem_we    = 1'b1;
      end else begin
        mem_we = 1'b0;
      end
    end else begin
      mem_we = 1'b0;
    end
  end

  // Sequencer state, round-robin pointer and registered responses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      prio_r      <= 1'b0;
      rmw_port_r  <= 1'b0;
      rmw_addr_r  <= 32'h0;
      rmw_data_r  <= 32'h0;
      rsp_valid_0 <= 1'b0;
      rsp_rdata_0 <= 32'h0;
      rsp_err_0   <= 1'b0;
      rsp_valid_1 <= 1'b0;
      rsp_rdata_1 <= 32'h0;
      rsp_err_1   <= 1'b0;
    end else begin
      rsp_valid_0 <= 1'b0;
      rsp_rdata_0 <= 32'h0;
      rsp_err_0   <= 1'b0;
      rsp_valid_1 <= 1'b0;
      rsp_rdata_1 <= 32'h0;
      rsp_err_1   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            prio_r <= ~grant_port_s;
            if (in_range_s && partial_s) begin
              state_r    <= ST_RMW;
              rmw_port_r <= grant_port_s;
              rmw_addr_r <= sel_addr_s;
              rmw_data_r <= merged_s;
            end else if (grant_port_s) begin
              rsp_valid_1 <= 1'b1;
              rsp_err_1   <= ~in_range_s;
              rsp_rdata_1 <= (!sel_we_s && in_range_s) ? mem_rdata : 32'h0;
            end else begin
              rsp_valid_0 <= 1'b1;
              rsp_err_0   <= ~in_range_s;
              rsp_rdata_0 <= (!sel_we_s && in_range_s) ? mem_rdata : 32'h0;
            end
          end
        end
        ST_RMW: begin
          state_r <= ST_IDLE;
          if (rmw_port_r) begin
            rsp_valid_1 <= 1'b1;
          end else begin
            rsp_valid_0 <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 2048-word memory.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req_valid_0, req_ready_0, req_we_0, rsp_valid_0, rsp_err_0;
  logic [31:0] req_addr_0, req_wdata_0, rsp_rdata_0;
  logic [3:0]  req_be_0;
  logic        req_valid_1, req_ready_1, req_we_1, rsp_valid_1, rsp_err_1;
  logic [31:0] req_addr_1, req_wdata_1, rsp_rdata_1;
  logic [3:0]  req_be_1;
  logic [31:0] mem_a, mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] mem [0:2047];
  int errors = 0;
  int checks = 0;

  dmem_arbiter #(.MEM_SIZE(2000)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_we_0(req_we_0),
    .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0), .req_be_0(req_be_0),
    .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0), .rsp_err_0(rsp_err_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_we_1(req_we_1),
    .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1), .req_be_1(req_be_1),
    .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1), .rsp_err_1(rsp_err_1),
    .mem_a(mem_a), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = (mem_a < 32'd2000) ? mem[mem_a[10:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we && (mem_a < 32'd2000)) mem[mem_a[10:0]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set0(input logic v, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    req_valid_0 = v; req_we_0 = we; req_addr_0 = a; req_wdata_0 = d; req_be_0 = be;
  endtask

  task automatic set1(input logic v, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    req_valid_1 = v; req_we_1 = we; req_addr_1 = a; req_wdata_1 = d; req_be_1 = be;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    mem[3]    = 32'h12345678;
    mem[7]    = 32'h11223344;
    mem[1999] = 32'h5A5A5A5A;
    rst_n = 1'b0;
    set0(1'b1, 1'b0, 32'd5, 32'h0, 4'hF);
    set1(1'b0, 1'b0, 32'd0, 32'h0, 4'h0);

    // Reset state
    tick(); tick(); settle();
    chk("rst_ready0", {31'd0, req_ready_0}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_rsp_valid0", {31'd0, rsp_valid_0}, 32'd0);
    chk("rst_rsp_rdata0", rsp_rdata_0, 32'h0);
    chk("rst_rsp_err0", {31'd0, rsp_err_0}, 32'd0);
    rst_n = 1'b1;

    // Full store then load on port 0
    set0(1'b1, 1'b1, 32'd5, 32'hDEADBEEF, 4'hF); settle();
    chk("st_ready0", {31'd0, req_ready_0}, 32'd1);
    chk("st_mem_we", {31'd0, mem_we}, 32'd1);
    chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("st_mem_a", mem_a, 32'd5);
    tick();
    chk("st_rsp_valid0", {31'd0, rsp_valid_0}, 32'd1);
    chk("st_rsp_err0", {31'd0, rsp_err_0}, 32'd0);
    chk("st_rsp_valid1", {31'd0, rsp_valid_1}, 32'd0);
    set0(1'b1, 1'b0, 32'd5, 32'h0, 4'hF); settle();
    chk("ld_ready0", {31'd0, req_ready_0}, 32'd1);
    chk("ld_mem_we", {31'd0, mem_we}, 32'd0);
    tick();
    chk("ld_rsp_valid0", {31'd0, rsp_valid_0}, 32'd1);
    chk("ld_rdata0", rsp_rdata_0, 32'hDEADBEEF);

    // Partial store on port 1 (port 0 also requesting during RMW)
    set0(1'b0, 1'b0, 32'd0, 32'h0, 4'h0);
    set1(1'b1, 1'b1, 32'd7, 32'hAABBCCDD, 4'b0101); settle();
    chk("ps_n_ready1", {31'd0, req_ready_1}, 32'd1);
    chk("ps_n_mem_we", {31'd0, mem_we}, 32'd0);
    chk("ps_n_mem_a", mem_a, 32'd7);
    tick();
    set0(1'b1, 1'b0, 32'd5, 32'h0, 4'hF); settle();
    chk("ps_n1_ready0", {31'd0, req_ready_0}, 32'd0);
    chk("ps_n1_ready1", {31'd0, req_ready_1}, 32'd0);
    chk("ps_n1_mem_we", {31'd0, mem_we}, 32'd1);
    chk("ps_n1_mem_wdata", mem_wdata, 32'h11BB33DD);
    chk("ps_n1_mem_a", mem_a, 32'd7);
    chk("ps_n1_rsp_valid1", {31'd0, rsp_valid_1}, 32'd0);
    tick();
    chk("ps_n2_rsp_valid1", {31'd0, rsp_valid_1}, 32'd1);
    chk("ps_n2_rsp_valid0", {31'd0, rsp_valid_0}, 32'd0);
    chk("ps_mem7", mem[7], 32'h11BB33DD);
    set0(1'b0, 1'b0, 32'd0, 32'h0, 4'h0);
    set1(1'b1, 1'b0, 32'd7, 32'h0, 4'hF); settle();
    chk("ps_ld_ready1", {31'd0, req_ready_1}, 32'd1);
    tick();
    chk("ps_ld_rdata1", rsp_rdata_1, 32'h11BB33DD);
    chk("ps_ld_rsp_valid0", {31'd0, rsp_valid_0}, 32'd0);

    // Contention from reset: grants alternate 0,1,0,1,0,1
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    set0(1'b1, 1'b0, 32'd5, 32'h0, 4'hF);
    set1(1'b1, 1'b0, 32'd7, 32'h0, 4'hF);
    for (int i = 0; i < 6; i++) begin
      settle();
      chk("ct_ready0", {31'd0, req_ready_0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("ct_ready1", {31'd0, req_ready_1}, (i % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      chk("ct_rsp_valid0", {31'd0, rsp_valid_0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("ct_rsp_valid1", {31'd0, rsp_valid_1}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i % 2 == 0) chk("ct_rdata0", rsp_rdata_0, 32'hDEADBEEF);
      else            chk("ct_rdata1", rsp_rdata_1, 32'h11BB33DD);
    end
    set1(1'b0, 1'b0, 32'd0, 32'h0, 4'h0);

    // Out-of-range load, full store, partial store; last valid address
    set0(1'b1, 1'b0, 32'd2000, 32'h0, 4'hF); settle();
    chk("oor_ld_ready0", {31'd0, req_ready_0}, 32'd1);
    chk("oor_ld_mem_we", {31'd0, mem_we}, 32'd0);
    tick();
    chk("oor_ld_valid0", {31'd0, rsp_valid_0}, 32'd1);
    chk("oor_ld_err0", {31'd0, rsp_err_0}, 32'd1);
    chk("oor_ld_rdata0", rsp_rdata_0, 32'h0);
    set0(1'b1, 1'b1, 32'hFFFFFFFF, 32'hCAFEF00D, 4'hF); settle();
    chk("oor_st_mem_we", {31'd0, mem_we}, 32'd0);
    tick();
    chk("oor_st_err0", {31'd0, rsp_err_0}, 32'd1);
    chk("oor_st_mem5", mem[5], 32'hDEADBEEF);
    set0(1'b1, 1'b1, 32'd2000, 32'hCAFEF00D, 4'b0101); settle();
    chk("oor_ps_mem_we", {31'd0, mem_we}, 32'd0);
    tick();
    chk("oor_ps_valid0", {31'd0, rsp_valid_0}, 32'd1);
    chk("oor_ps_err0", {31'd0, rsp_err_0}, 32'd1);
    set0(1'b1, 1'b0, 32'd1999, 32'h0, 4'hF); settle();
    chk("edge_ready0", {31'd0, req_ready_0}, 32'd1);
    tick();
    chk("edge_err0", {31'd0, rsp_err_0}, 32'd0);
    chk("edge_rdata0", rsp_rdata_0, 32'h5A5A5A5A);

    // Zero byte-enable store
    set0(1'b1, 1'b1, 32'd3, 32'hFFFFFFFF, 4'h0); settle();
    chk("be0_ready0", {31'd0, req_ready_0}, 32'd1);
    chk("be0_mem_we", {31'd0, mem_we}, 32'd0);
    tick();
    chk("be0_valid0", {31'd0, rsp_valid_0}, 32'd1);
    chk("be0_err0", {31'd0, rsp_err_0}, 32'd0);
    chk("be0_mem_we_after", {31'd0, mem_we}, 32'd0);
    chk("be0_mem3", mem[3], 32'h12345678);

    // Reset during RMW: write abandoned, no response, prio back to 0
    set0(1'b1, 1'b1, 32'd7, 32'hFF000000, 4'b1000); settle();
    chk("rr_ready0", {31'd0, req_ready_0}, 32'd1);
    tick();
    set0(1'b0, 1'b0, 32'd0, 32'h0, 4'h0);
    rst_n = 1'b0; settle();
    chk("rr_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rr_ready0_low", {31'd0, req_ready_0}, 32'd0);
    tick();
    chk("rr_rsp_valid0", {31'd0, rsp_valid_0}, 32'd0);
    chk("rr_rsp_valid1", {31'd0, rsp_valid_1}, 32'd0);
    chk("rr_mem7", mem[7], 32'h11BB33DD);
    rst_n = 1'b1;
    set0(1'b1, 1'b0, 32'd5, 32'h0, 4'hF);
    set1(1'b1, 1'b0, 32'd7, 32'h0, 4'hF); settle();
    chk("rr_prio_ready0", {31'd0, req_ready_0}, 32'd1);
    chk("rr_prio_ready1", {31'd0, req_ready_1}, 32'd0);
    tick();
    chk("rr_post_valid0", {31'd0, rsp_valid_0}, 32'd1);
    chk("rr_post_rdata0", rsp_rdata_0, 32'hDEADBEEF);
    set0(1'b0, 1'b0, 32'd0, 32'h0, 4'h0);
    set1(1'b0, 1'b0, 32'd0, 32'h0, 4'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
